seq_pattern_detector: RTL and testbench
=======================================

# seq_pattern_detector

Parametrised serial pattern detector: a generalised successor to the team's fixed 4-state Mealy sequence FSMs. It watches a 1-bit serial stream qualified by a valid strobe and flags each occurrence of a run-time-loadable W-bit pattern. Overlapping or non-overlapping detection is selectable. It provides a combinational Mealy flag, a registered flag and a saturating match counter. It sits between a serial line front-end and control logic that reacts to framing and sync words.

## Interface
- W, 4: pattern length in bits, W ≥ 2.
- CNT_W, 8: match counter width.
- RESET_PATTERN, {W{1'b0}}: pattern register value after reset.

- clk, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high reset.
- pattern_load, input, 1: load `pattern_in` into the pattern register.
- pattern_in, input, W: new pattern. Bit W-1 is matched against the oldest (first-arriving) bit.
- overlap, input, 1: 1 means overlapping detection, 0 means non-overlapping.
- in_valid, input, 1: `x` carries a stream bit this cycle.
- x, input, 1: serial data bit.
- y, output, 1: combinational Mealy match flag for the current cycle.
- y_reg, output, 1: `y` registered, one cycle later.
- match_count, output, CNT_W: number of matches since reset or load; saturates.
- armed, output, 1: high when the next valid bit can complete a match (state ARMED).

## Operation
- Internal registers:
  - `pat` [W-1:0]: pattern register.
  - `hist` [W-2:0]: the last W-1 accepted bits, newest in bit 0.
  - `fill`: count of bits, 0..W-1.
  - A 2-bit state.
- States:
  - IDLE: fill == 0.
  - FILLING: 0 < fill < W-1.
  - ARMED: fill == W-1.
- Match condition: `y = in_valid & (state==ARMED) & ({hist, x} == pat) & ~pattern_load`.
- On an accepted bit (in_valid=1, pattern_load=0):
  - `hist <= {hist[W-3:0], x}`.
  - Transitions when there is no match:
    - IDLE → FILLING, or straight to ARMED if W == 2.
    - FILLING → FILLING or ARMED as fill increments.
    - ARMED → ARMED.
  - Transitions on a match:
    - overlap=1: stay in ARMED; hist shifts normally.
    - overlap=0: go to IDLE with fill=0. hist content is don't-care.
  - On a match, `match_count` increments, saturating at 2^CNT_W-1.
- in_valid=0: no change to hist, fill or state. y=0.
- pattern_load=1 takes priority over in_valid:
  - `pat <= pattern_in`, state goes to IDLE, fill=0, `match_count <= 0`.
  - The bit on `x` in that cycle is discarded and y=0.
- `overlap` is sampled each cycle. Changing it mid-stream affects only matches from that cycle on.
- `armed` = (state == ARMED).

## Timing
- Reset values:
  - pat=RESET_PATTERN, state IDLE, fill=0, hist=0.
  - y_reg=0, match_count=0, armed=0.
  - y=0 while reset is high; reset overrides pattern_load and in_valid.
- Latency:
  - y asserts in the same cycle as the W-th bit of the pattern, with zero latency.
  - y_reg and match_count update at the following rising edge.
- First possible match is on the W-th accepted bit after reset, load or a non-overlap match.
- Minimum spacing between consecutive y pulses:
  - 1 valid bit in overlap mode.
  - W valid bits in non-overlap mode.
- Reset mid-pattern: partial history is lost, and a pattern straddling the reset is not detected.
- Counter saturation: once at all-ones, further matches still pulse y and y_reg but the count is held.

## Test plan
- Reset, then W=4, pat=4'b1011, overlap=1, stream 1,0,1,1,0,1,1 (all valid) → y high on bit 4 and bit 7, match_count=2, y_reg high the cycle after each.
- Same stream with overlap=0 → y only on bit 4. Bits 5–7 refill to fill=3 with no match. match_count=1.
- pat=4'b1111, overlap=1, seven 1s → y on bits 4,5,6,7, count=4. With overlap=0 → y on bit 4 only, count=1 (the next match would be bit 8).
- Stream 1,0,1 then in_valid=0 for 5 cycles, then 1 → y on the resumed bit. Gaps do not break the pattern and armed stays high during the gap.
- pattern_load asserted while ARMED with x completing the old pattern → y=0, count=0, state IDLE, new pattern active. Reset asserted mid-stream → all outputs return to reset values the next edge.
- CNT_W=2, pat=2'b11 (W=2), overlap=1, six 1s → five y pulses, match_count stops at 3.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: flags each occurrence of a loadable W-bit pattern in a
// valid-qualified bit stream, with overlap control, a registered flag and a saturating count.
module seq_pattern_detector #(
    parameter int             W             = 4,
    parameter int             CNT_W         = 8,
    parameter logic [W-1:0]   RESET_PATTERN = {W{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pattern_load,
    input  logic [W-1:0]     pattern_in,
    input  logic             overlap,
    input  logic             in_valid,
    input  logic             x,
    output logic             y,
    output logic             y_reg,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int                FILL_W    = $clog2(W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILLING = 2'd1,
        ST_ARMED   = 2'd2
    } state_t;

    state_t              r_state;
    logic [W-1:0]        r_pat;
    logic [W-2:0]        r_hist;
    logic [FILL_W-1:0]   r_fill;
    logic                r_y_reg;
    logic [CNT_W-1:0]    r_count;

    logic [W-1:0]        w_window;
    logic [FILL_W-1:0]   w_fill_next;
    logic                w_match;

    // The window is the stored history with the incoming bit appended as newest.
    assign w_window    = {r_hist, x};
    assign w_fill_next = r_fill + FILL_W'(1);
    assign w_match     = in_valid & (r_state == ST_ARMED) & (w_window == r_pat)
                       & ~pattern_load & ~reset;

    assign y           = w_match;
    assign y_reg       = r_y_reg;
    assign match_count = r_count;
    assign armed       = (r_state == ST_ARMED);

    // Detector FSM, history shifter, registered flag and saturating match counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pat   <= RESET_PATTERN;
            r_state <= ST_IDLE;
            r_fill  <= {FILL_W{1'b0}};
            r_hist  <= {(W-1){1'b0}};
            r_y_reg <= 1'b0;
            r_count <= {CNT_W{1'b0}};
        end else if (pattern_load) begin
            r_pat   <= pattern_in;
            r_state <= ST_IDLE;
            r_fill  <= {FILL_W{1'b0}};
            r_y_reg <= 1'b0;
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_y_reg <= w_match;
            if (in_valid) begin
                r_hist <= w_window[W-2:0];
                if (w_match) begin
                    if (r_count != CNT_MAX) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    // Non-overlap restarts from an empty window so no bit is reused.
                    if (!overlap) begin
                        r_state <= ST_IDLE;
                        r_fill  <= {FILL_W{1'b0}};
                    end
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_fill  <= w_fill_next;
                            r_state <= (w_fill_next == FILL_LAST) ? ST_ARMED : ST_FILLING;
                        end
                        ST_FILLING: begin
                            r_fill  <= w_fill_next;
                            r_state <= (w_fill_next == FILL_LAST) ? ST_ARMED : ST_FILLING;
                        end
                        ST_ARMED: begin
                            r_state <= ST_ARMED;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_fill  <= {FILL_W{1'b0}};
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Randomised and directed bench for seq_pattern_detector against a queue-based model.
module tb_seq_pattern_detector;

    localparam int W = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, pattern_load, overlap, in_valid, x;
    logic [3:0] pattern_in;
    logic       y, y_reg, armed;
    logic [7:0] match_count;

    logic       d2_reset, d2_load, d2_overlap, d2_valid, d2_x;
    logic [1:0] d2_pin, d2_count;
    logic       d2_y, d2_yreg, d2_armed;

    int tests = 0;
    int fails = 0;

    int         m_q[$];
    logic [3:0] m_pat;
    int         m_cnt;
    logic       m_yreg;
    logic       exp_y, obs_y;
    logic [9:0] exp_v, obs_v;

    seq_pattern_detector #(.W(4), .CNT_W(8), .RESET_PATTERN(4'b0000)) dut (
        .clk(clk), .reset(reset), .pattern_load(pattern_load), .pattern_in(pattern_in),
        .overlap(overlap), .in_valid(in_valid), .x(x), .y(y), .y_reg(y_reg),
        .match_count(match_count), .armed(armed)
    );

    seq_pattern_detector #(.W(2), .CNT_W(2), .RESET_PATTERN(2'b00)) dut2 (
        .clk(clk), .reset(d2_reset), .pattern_load(d2_load), .pattern_in(d2_pin),
        .overlap(d2_overlap), .in_valid(d2_valid), .x(d2_x), .y(d2_y), .y_reg(d2_yreg),
        .match_count(d2_count), .armed(d2_armed)
    );

    // Drive one cycle; model keeps the accepted bits since the last restart and
    // matches when W-1 stored bits plus the new bit spell the pattern.
    task automatic step(input logic rst, input logic ld, input logic v, input logic xb,
                        input logic ov, input logic [3:0] pin);
        int   val;
        logic hit;
        @(negedge clk);
        reset = rst; pattern_load = ld; in_valid = v; x = xb; overlap = ov; pattern_in = pin;
        #1;
        obs_y = y;
        hit = 1'b0;
        if (rst) begin
            m_q.delete(); m_pat = 4'b0000; m_cnt = 0;
        end else if (ld) begin
            m_q.delete(); m_pat = pin; m_cnt = 0;
        end else if (v) begin
            if (m_q.size() == W-1) begin
                val = 0;
                foreach (m_q[i]) val = val * 2 + m_q[i];
                val = val * 2 + int'(xb);
                hit = (val == int'(m_pat));
            end
            if (hit && !ov) begin
                m_q.delete();
            end else begin
                m_q.push_back(int'(xb));
                if (m_q.size() > W-1) void'(m_q.pop_front());
            end
            if (hit && m_cnt < 255) m_cnt++;
        end
        exp_y  = hit;
        m_yreg = hit;
        @(posedge clk);
        #1;
        obs_v = {y_reg, armed, match_count};
        exp_v = {m_yreg, (m_q.size() == W-1), 8'(m_cnt)};
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111);
        tests++;
        if (obs_y !== 1'b0 || obs_v !== 10'b0) begin
            fails++;
            $display("FAIL reset: y=%b yreg/armed/cnt=%h, required y=0 all zero", obs_y, obs_v);
        end
    endtask

    task automatic test_stream(input string name, input logic [3:0] p, input logic ov,
                               input logic [7:0] s, input int n,
                               input logic [7:0] exp_ys, input int exp_cnt);
        logic [7:0] ys;
        ys = 8'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, ov, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, ov, p);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b1, s[i], ov, 4'b0000);
            ys[i] = obs_y;
            tests++;
            if (obs_y !== exp_y || obs_v !== exp_v) begin
                fails++;
                $display("FAIL %s bit%0d: y=%b st=%h, required y=%b st=%h",
                         name, i+1, obs_y, obs_v, exp_y, exp_v);
            end
        end
        tests++;
        if (ys !== exp_ys || match_count !== 8'(exp_cnt)) begin
            fails++;
            $display("FAIL %s summary: ys=%b cnt=%0d, required ys=%b cnt=%0d",
                     name, ys, match_count, exp_ys, exp_cnt);
        end
    endtask

    task automatic test_gap();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
            tests++;
            if (obs_y !== 1'b0 || armed !== 1'b1 || match_count !== 8'd0) begin
                fails++;
                $display("FAIL gap idle%0d: y=%b armed=%b cnt=%0d, required 0 1 0",
                         i, obs_y, armed, match_count);
            end
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        tests++;
        if (obs_y !== 1'b1 || y_reg !== 1'b1 || match_count !== 8'd1) begin
            fails++;
            $display("FAIL gap resume: y=%b yreg=%b cnt=%0d, required 1 1 1", obs_y, y_reg, match_count);
        end
    endtask

    task automatic test_load_priority();
        logic [3:0] ys;
        logic [3:0] s;
        s = 4'b0110;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
        tests++;
        if (obs_y !== 1'b0 || obs_v !== 10'b0) begin
            fails++;
            $display("FAIL load_prio: y=%b st=%h, required y=0 st=000", obs_y, obs_v);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, s[i], 1'b1, 4'b0000);
            ys[i] = obs_y;
        end
        tests++;
        if (ys !== 4'b1000 || match_count !== 8'd1) begin
            fails++;
            $display("FAIL load_newpat: ys=%b cnt=%0d, required ys=1000 cnt=1", ys, match_count);
        end
    endtask

    task automatic test_reset_midstream();
        logic [3:0] ys;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        tests++;
        if (obs_y !== 1'b0 || obs_v !== 10'b0) begin
            fails++;
            $display("FAIL reset_mid: y=%b st=%h, required y=0 st=000", obs_y, obs_v);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
            ys[i] = obs_y;
        end
        tests++;
        if (ys !== 4'b1000) begin
            fails++;
            $display("FAIL reset_straddle: ys=%b, required 1000", ys);
        end
    endtask

    task automatic test_random();
        int r;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            step(r == 0, (r >= 1 && r <= 3), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            tests++;
            if (obs_y !== exp_y || obs_v !== exp_v) begin
                fails++;
                $display("FAIL random step%0d: y=%b st=%h, required y=%b st=%h",
                         i, obs_y, obs_v, exp_y, exp_v);
            end
        end
    endtask

    task automatic test_saturation();
        int pulses;
        pulses = 0;
        @(negedge clk);
        d2_reset = 1'b1; d2_valid = 1'b1; d2_x = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (d2_count !== 2'd0 || d2_armed !== 1'b0 || d2_yreg !== 1'b0) begin
            fails++;
            $display("FAIL sat_reset: cnt=%0d armed=%b yreg=%b, required 0 0 0", d2_count, d2_armed, d2_yreg);
        end
        @(negedge clk);
        d2_reset = 1'b0; d2_load = 1'b1; d2_pin = 2'b11;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            d2_load = 1'b0; d2_valid = 1'b1; d2_x = 1'b1; d2_overlap = 1'b1;
            #1;
            if (d2_y === 1'b1) pulses++;
            tests++;
            if (d2_y !== (i >= 1)) begin
                fails++;
                $display("FAIL sat_y bit%0d: y=%b, required %b", i+1, d2_y, (i >= 1));
            end
            @(posedge clk); #1;
            tests++;
            if (d2_count !== 2'((i > 3) ? 3 : i) || d2_yreg !== (i >= 1) || d2_armed !== 1'b1) begin
                fails++;
                $display("FAIL sat_cnt bit%0d: cnt=%0d yreg=%b armed=%b, required %0d %b 1",
                         i+1, d2_count, d2_yreg, d2_armed, (i > 3) ? 3 : i, (i >= 1));
            end
        end
        tests++;
        if (pulses != 5) begin
            fails++;
            $display("FAIL sat_pulses: %0d, required 5", pulses);
        end
    endtask

    initial begin
        reset = 1'b1; pattern_load = 1'b0; overlap = 1'b1; in_valid = 1'b0; x = 1'b0;
        pattern_in = 4'b0000;
        d2_reset = 1'b1; d2_load = 1'b0; d2_overlap = 1'b1; d2_valid = 1'b0; d2_x = 1'b0;
        d2_pin = 2'b00;
        m_pat = 4'b0000; m_cnt = 0; m_yreg = 1'b0;

        test_reset();
        test_stream("overlap_1011",    4'b1011, 1'b1, 8'b01101101, 7, 8'b01001000, 2);
        test_stream("nonoverlap_1011", 4'b1011, 1'b0, 8'b01101101, 7, 8'b00001000, 1);
        test_stream("overlap_1111",    4'b1111, 1'b1, 8'b01111111, 7, 8'b01111000, 4);
        test_stream("nonoverlap_1111", 4'b1111, 1'b0, 8'b11111111, 8, 8'b10001000, 2);
        test_gap();
        test_load_priority();
        test_reset_midstream();
        test_random();
        test_saturation();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
